// File: rtl/step_gen_pkg.sv
// Shared definitions for the step generator datapath.
//   STEP_W    : default counter width
//   step_t    : STEP_W-bit step value
//   COUNT_RST : counter value after reset
package step_gen_pkg;
  localparam int STEP_W = 4;
  typedef logic [STEP_W-1:0] step_t;
  localparam step_t COUNT_RST = '0;
endpackage

// File: rtl/tick_edge_detect.sv
// Registered rising-edge detector for the tick input.
//   clk  : system clock
//   rst  : async active-high reset
//   tick : level input
//   rise : high in the cycle where tick is 1 and was 0 on the previous edge
// The register holds "tick was low at the last edge" and resets to 0.
// As a result, a tick that is already high at reset release is not seen
// as an edge until it has been observed low at least once.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic rise
);
  logic low_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) low_q <= 1'b0;
    else     low_q <= ~tick;
  end

  assign rise = tick & low_q;
endmodule

// File: rtl/step_counter.sv
// Programmable modulo step counter: count runs 0..steps and wraps to 0.
//   clk   : system clock
//   rst   : async active-high reset, clears count
//   tick  : advance request (level; rising edge with STEP_COUNTER_TICK_EDGE_EN)
//   steps : inclusive terminal count, may change at any time
//   count : registered current count
// Build option: define STEP_COUNTER_TICK_EDGE_EN to advance only on a 0->1
// transition of tick instead of on every edge where tick is high.
module step_counter
  import step_gen_pkg::*;
#(
  parameter int WIDTH = STEP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] steps,
  output logic [WIDTH-1:0] count
);
  logic adv;

`ifdef STEP_COUNTER_TICK_EDGE_EN
  tick_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .rise (adv)
  );
`else
  assign adv = tick;
`endif

  // Wrap on >= rather than == so a steps value lowered below the current
  // count still returns to 0 on the next advance; this also keeps count+1
  // from overflowing when steps is all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= WIDTH'(COUNT_RST);
    else if (adv)
      count <= (count >= steps) ? '0 : count + WIDTH'(1);
  end
endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter: directed sequences followed by random
// stimulus, with expected counts queued by the driver and checked by a monitor.
module tb_step_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [W-1:0] steps;
  logic [W-1:0] count;

  int checks = 0;
  int errors = 0;

  int unsigned exp_q[$];
  string       name_q[$];

  // reference state
  int unsigned m_count = 0;
  bit          m_low_seen = 0;
  string       cur_name = "reset";

  step_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .steps (steps),
    .count (count)
  );

  always #5 clk = ~clk;

  // Reference: one advance moves to the next value in 0..steps, wrapping
  // whenever the count is already at or beyond the terminal value.
  function automatic int unsigned next_val(int unsigned c, int unsigned s);
    if (c >= s) return 0;
    return c + 1;
  endfunction

  // Model step at a rising clk edge, using the inputs driven for this cycle.
  task automatic model_edge();
    bit adv;
    if (rst) begin
      m_count    = 0;
      m_low_seen = 0;
    end else begin
`ifdef STEP_COUNTER_TICK_EDGE_EN
      adv = tick && m_low_seen;
      m_low_seen = !tick;
`else
      adv = tick;
`endif
      if (adv) m_count = next_val(m_count, steps);
    end
    exp_q.push_back(m_count);
    name_q.push_back(cur_name);
  endtask

  task automatic cyc(input bit t, input int unsigned s, input bit r);
    @(negedge clk);
    tick  = t;
    steps = W'(s);
    rst   = r;
    @(posedge clk);
    model_edge();
  endtask

  // Monitor: count is observable shortly after every clk edge and after any
  // asynchronous reset assertion.
  always @(posedge clk or posedge rst) begin
    #1;
    while (exp_q.size() > 0) begin
      int unsigned e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (count !== W'(e)) begin
        errors++;
        $display("FAIL %s: count=%0d expected=%0d at %0t", n, count, e, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; steps = W'(5);

    cur_name = "reset";
    repeat (2) cyc(0, 5, 1);
    cur_name = "hold_after_reset";
    repeat (2) cyc(0, 5, 0);

    cur_name = "mod6";
    for (int i = 0; i < 8; i++) begin
      cyc(1, 5, 0);
      cyc(0, 5, 0);
    end

    cur_name = "steps3_from2";
    for (int i = 0; i < 5; i++) cyc(1, 3, 0);

    cur_name = "steps0";
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end

    cur_name = "steps_reduced";
    cyc(0, 5, 1);
    cyc(0, 5, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 5, 0);
      cyc(0, 5, 0);
    end
    cyc(1, 2, 0);
    cyc(0, 2, 0);
    cyc(1, 2, 0);
    cyc(0, 2, 0);

    cur_name = "async_reset";
    cyc(0, 5, 1);
    cyc(0, 5, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 5, 0);
      cyc(0, 5, 0);
    end
    // assert reset between edges; the monitor checks before the next edge
    @(negedge clk);
    rst = 1'b1;
    m_count = 0;
    m_low_seen = 0;
    exp_q.push_back(0);
    name_q.push_back("async_reset_mid");
    cyc(0, 5, 1);
    cyc(0, 5, 0);

    cur_name = "tick_held";
    for (int i = 0; i < 4; i++) cyc(1, 9, 0);
    cyc(0, 9, 0);

    cur_name = "full_range";
    for (int i = 0; i < 20; i++) cyc(1, 15, 0);

    cur_name = "random";
    for (int i = 0; i < 400; i++) begin
      bit          t, r;
      int unsigned s;
      t = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 3);
      s = (i % 50 < 40) ? steps : $urandom_range(0, 15);
      cyc(t, s, r);
    end

    cur_name = "drain";
    repeat (3) cyc(0, 5, 0);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
